mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the scalar pipeline, directly downstream of execute and upstream of writeback.
- Consumes the ALU result, opcode, destination index and value, and stall flags from execute.
- Performs LDW/STW through a request/acknowledge data-memory port and maintains the NZP condition codes.
- Resolves branches and jumps, and forwards results to writeback.

Parameters:
- REG_WIDTH, 16, data word width.
- PC_WIDTH, 16, branch target width.
- OPCODE_WIDTH, 8, opcode field width.
- MEM_TIMEOUT, 15, max cycles in WAIT before forced completion.

Ports:
- I_CLOCK  in  1  stage clock; all state updates on falling edge.
- I_RESET_N  in  1  synchronous active-low reset.
- I_LOCK  in  1  execute output valid.
- I_Opcode  in  OPCODE_WIDTH  opcode from execute.
- I_ALUOut  in  REG_WIDTH  ALU result, memory address, or branch target.
- I_DestRegIdx  in  4  destination register index.
- I_DestValue  in  REG_WIDTH  store data, or link value for JSR/JSRR.
- I_FetchStall  in  1  fetch bubble marker.
- I_DepStall  in  1  dependency bubble marker.
- I_MemAck  in  1  data memory completion.
- I_MemRData  in  REG_WIDTH  load data, valid with I_MemAck.
- O_MemReq  out  1  memory request, held until ack.
- O_MemWe  out  1  1 = STW, 0 = LDW.
- O_MemAddr  out  REG_WIDTH  access address.
- O_MemWData  out  REG_WIDTH  store data.
- O_MemStall  out  1  upstream must hold its outputs.
- O_LOCK  out  1  output valid to writeback.
- O_Opcode  out  OPCODE_WIDTH  opcode to writeback.
- O_DestRegIdx  out  4  destination index.
- O_DestValue  out  REG_WIDTH  writeback data.
- O_FetchStall  out  1  forwarded bubble flag.
- O_DepStall  out  1  forwarded bubble flag.
- O_BranchTaken  out  1  one-cycle redirect pulse.
- O_BranchTarget  out  PC_WIDTH  redirect address.
- O_CC  out  3  current NZP.
- O_MemErr  out  1  sticky timeout flag.

Behaviour:
- Reset (I_RESET_N=0 at a falling edge): all outputs 0, CC=3'b010 (Z), state IDLE, timeout counter 0, O_MemErr cleared.
- Reset during WAIT aborts the access: O_MemReq drops on that edge and no writeback is issued.
- An instruction is active when I_LOCK=1, I_FetchStall=0 and I_DepStall=0.
- Bubbles (inactive input):
  - O_LOCK, O_FetchStall, O_DepStall follow the inputs.
  - No CC update, no branch, no memory request.
- FSM has two states, IDLE and WAIT.
- IDLE, non-memory ops:
  - Registered in one cycle: O_LOCK=1, O_DestValue=I_ALUOut.
  - For JSR/JSRR, O_DestValue=I_DestValue instead.
- IDLE, active LDW/STW:
  - Latch O_MemAddr=I_ALUOut, O_MemWData=I_DestValue, O_MemWe.
  - Assert O_MemReq and O_MemStall, set O_LOCK=0, go to WAIT.
- WAIT:
  - Hold request fields and O_MemStall=1; inputs are ignored because upstream holds them.
  - Counter increments each cycle.
  - On I_MemAck=1: drop O_MemReq and O_MemStall, O_LOCK=1, O_DestValue = I_MemRData (LDW) or store data (STW), return to IDLE.
  - Latency: address out one edge after acceptance; result one edge after ack.
- Timeout: if the counter reaches MEM_TIMEOUT without ack, complete as if ack arrived with data 0 and set O_MemErr (sticky until reset).
- Ack and timeout on the same edge: ack wins, O_MemErr is not set.
- I_MemAck in IDLE is ignored.
- Condition codes:
  - Updated by ADD, ADDI, AND, ANDI, MOV, MOVI, and LDW (at completion) from the written value.
  - N if MSB=1, Z if value==0, else P.
  - STW, branches and jumps leave CC unchanged.
- Branches:
  - Mask per opcode: BRN 100, BRZ 010, BRP 001, BRNZ 110, BRNP 101, BRZP 011, BRNZP 111.
  - Taken if (mask & CC) != 0, using CC before this instruction.
  - JSR, JSRR and JMP are always taken.
  - When taken: O_BranchTaken=1 for exactly one cycle, O_BranchTarget=I_ALUOut[PC_WIDTH-1:0].
- O_Opcode, O_DestRegIdx, O_FetchStall and O_DepStall are registered alongside O_LOCK in every case.

Decomposition:
- Opcode macros come from global_def.h.
- Add to the shared header:
  - CC encodings (CC_N, CC_Z, CC_P).
  - mem_stage FSM state encodings.
  - MEM_TIMEOUT default.
- One combinational sub-module, branch_resolve: inputs opcode and CC; outputs is_branch and taken.

Test Plan:
- MOVI result 0x0000, then BRZ with target 0x0040 -> CC=010; O_BranchTaken pulses once with O_BranchTarget=0x0040.
- ADD result 0x8001, then BRP -> CC=100; no branch; O_LOCK=1 for both instructions.
- LDW addr 0x0010 with ack after 3 cycles, data 0x1234:
  - O_MemReq high 3 cycles and O_MemStall high for the same window.
  - O_DestValue=0x1234, CC=001.
- STW addr 0x0020, data 0xBEEF, ack in the first WAIT cycle -> O_MemWe=1, O_MemWData=0xBEEF; CC unchanged; O_LOCK=1 one edge after ack.
- LDW with no ack for 15 cycles -> forced completion with O_DestValue=0, O_MemErr=1; a later ack in IDLE is ignored.
- Reset asserted during WAIT -> next edge: O_MemReq=0, O_LOCK=0, CC=010, no writeback emitted.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: opcodes, condition codes, FSM states,
// and the timeout default.
package mem_stage_pkg;

  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_ADDI  = 8'h02;
  localparam logic [7:0] OP_AND   = 8'h03;
  localparam logic [7:0] OP_ANDI  = 8'h04;
  localparam logic [7:0] OP_MOV   = 8'h05;
  localparam logic [7:0] OP_MOVI  = 8'h06;
  localparam logic [7:0] OP_LDW   = 8'h07;
  localparam logic [7:0] OP_STW   = 8'h08;
  localparam logic [7:0] OP_BRN   = 8'h09;
  localparam logic [7:0] OP_BRZ   = 8'h0A;
  localparam logic [7:0] OP_BRP   = 8'h0B;
  localparam logic [7:0] OP_BRNZ  = 8'h0C;
  localparam logic [7:0] OP_BRNP  = 8'h0D;
  localparam logic [7:0] OP_BRZP  = 8'h0E;
  localparam logic [7:0] OP_BRNZP = 8'h0F;
  localparam logic [7:0] OP_JMP   = 8'h10;
  localparam logic [7:0] OP_JSR   = 8'h11;
  localparam logic [7:0] OP_JSRR  = 8'h12;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  localparam int MEM_TIMEOUT_DEF = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  function automatic logic [2:0] cc_from(input logic msb, input logic zero);
    return msb ? CC_N : (zero ? CC_Z : CC_P);
  endfunction

  function automatic logic writes_cc(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_AND) ||
           (op == OP_ANDI) || (op == OP_MOV) || (op == OP_MOVI);
  endfunction

endpackage

// File: rtl/mem_stage_branch_resolve.sv
// Branch decision: NZP mask per conditional branch, jumps unconditionally taken.
module branch_resolve
  import mem_stage_pkg::*;
#(
  parameter int OPCODE_WIDTH = 8
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [2:0]              cc,
  output logic                    is_branch,
  output logic                    taken
);

  logic [2:0] mask;
  logic       always_taken;

  always_comb begin
    mask         = 3'b000;
    is_branch    = 1'b0;
    always_taken = 1'b0;
    case (opcode)
      OP_BRN:   begin is_branch = 1'b1; mask = 3'b100; end
      OP_BRZ:   begin is_branch = 1'b1; mask = 3'b010; end
      OP_BRP:   begin is_branch = 1'b1; mask = 3'b001; end
      OP_BRNZ:  begin is_branch = 1'b1; mask = 3'b110; end
      OP_BRNP:  begin is_branch = 1'b1; mask = 3'b101; end
      OP_BRZP:  begin is_branch = 1'b1; mask = 3'b011; end
      OP_BRNZP: begin is_branch = 1'b1; mask = 3'b111; end
      OP_JMP, OP_JSR, OP_JSRR: begin is_branch = 1'b1; always_taken = 1'b1; end
      default:  ;
    endcase
    taken = is_branch && (always_taken || ((mask & cc) != 3'b000));
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: LDW/STW over a req/ack port with timeout, NZP condition codes,
// branch resolution and writeback forwarding. All state changes on the falling edge.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int REG_WIDTH    = 16,
  parameter int PC_WIDTH     = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_LOCK,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_DestValue,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  input  logic                    I_MemAck,
  input  logic [REG_WIDTH-1:0]    I_MemRData,
  output logic                    O_MemReq,
  output logic                    O_MemWe,
  output logic [REG_WIDTH-1:0]    O_MemAddr,
  output logic [REG_WIDTH-1:0]    O_MemWData,
  output logic                    O_MemStall,
  output logic                    O_LOCK,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [3:0]              O_DestRegIdx,
  output logic [REG_WIDTH-1:0]    O_DestValue,
  output logic                    O_FetchStall,
  output logic                    O_DepStall,
  output logic                    O_BranchTaken,
  output logic [PC_WIDTH-1:0]     O_BranchTarget,
  output logic [2:0]              O_CC,
  output logic                    O_MemErr
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  mem_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [2:0]             cc_d;
  logic                   req_d, we_d, stall_d, lock_d, fs_d, ds_d, br_d, err_d;
  logic [REG_WIDTH-1:0]   addr_d, wdata_d, val_d, ld_val;
  logic [OPCODE_WIDTH-1:0] op_d;
  logic [3:0]             idx_d;
  logic [PC_WIDTH-1:0]    tgt_d;
  logic                   active, is_mem, is_jsr, timeout, is_branch, br_taken;

  assign active  = I_LOCK && !I_FetchStall && !I_DepStall;
  assign is_mem  = (I_Opcode == OP_LDW) || (I_Opcode == OP_STW);
  assign is_jsr  = (I_Opcode == OP_JSR) || (I_Opcode == OP_JSRR);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = !I_MemAck && (cnt_inc == CNT_W'(MEM_TIMEOUT));
  assign ld_val  = I_MemAck ? I_MemRData : '0;

  branch_resolve #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_branch (
    .opcode    (I_Opcode),
    .cc        (O_CC),
    .is_branch (is_branch),
    .taken     (br_taken)
  );

  always_ff @(negedge I_CLOCK) begin
    if (!I_RESET_N) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      O_CC           <= CC_Z;
      O_MemReq       <= 1'b0;
      O_MemWe        <= 1'b0;
      O_MemAddr      <= '0;
      O_MemWData     <= '0;
      O_MemStall     <= 1'b0;
      O_LOCK         <= 1'b0;
      O_Opcode       <= '0;
      O_DestRegIdx   <= '0;
      O_DestValue    <= '0;
      O_FetchStall   <= 1'b0;
      O_DepStall     <= 1'b0;
      O_BranchTaken  <= 1'b0;
      O_BranchTarget <= '0;
      O_MemErr       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      O_CC           <= cc_d;
      O_MemReq       <= req_d;
      O_MemWe        <= we_d;
      O_MemAddr      <= addr_d;
      O_MemWData     <= wdata_d;
      O_MemStall     <= stall_d;
      O_LOCK         <= lock_d;
      O_Opcode       <= op_d;
      O_DestRegIdx   <= idx_d;
      O_DestValue    <= val_d;
      O_FetchStall   <= fs_d;
      O_DepStall     <= ds_d;
      O_BranchTaken  <= br_d;
      O_BranchTarget <= tgt_d;
      O_MemErr       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (active && is_mem) state_d = ST_WAIT;
      ST_WAIT: if (I_MemAck || timeout) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    cc_d    = O_CC;
    req_d   = O_MemReq;
    we_d    = O_MemWe;
    addr_d  = O_MemAddr;
    wdata_d = O_MemWData;
    stall_d = O_MemStall;
    lock_d  = O_LOCK;
    op_d    = O_Opcode;
    idx_d   = O_DestRegIdx;
    val_d   = O_DestValue;
    fs_d    = O_FetchStall;
    ds_d    = O_DepStall;
    br_d    = 1'b0;
    tgt_d   = O_BranchTarget;
    err_d   = O_MemErr;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        lock_d = I_LOCK;
        op_d   = I_Opcode;
        idx_d  = I_DestRegIdx;
        fs_d   = I_FetchStall;
        ds_d   = I_DepStall;
        val_d  = is_jsr ? I_DestValue : I_ALUOut;
        if (active && is_mem) begin
          addr_d  = I_ALUOut;
          wdata_d = I_DestValue;
          we_d    = (I_Opcode == OP_STW);
          req_d   = 1'b1;
          stall_d = 1'b1;
          lock_d  = 1'b0;
        end else if (active) begin
          if (writes_cc(I_Opcode))
            cc_d = cc_from(I_ALUOut[REG_WIDTH-1], I_ALUOut == '0);
          if (is_branch && br_taken) begin
            br_d  = 1'b1;
            tgt_d = I_ALUOut[PC_WIDTH-1:0];
          end
        end
      end
      ST_WAIT: begin
        lock_d = 1'b0;
        cnt_d  = cnt_inc;
        // Ack takes priority over timeout; only a missing ack raises the error.
        if (I_MemAck || timeout) begin
          req_d   = 1'b0;
          stall_d = 1'b0;
          lock_d  = 1'b1;
          cnt_d   = '0;
          val_d   = O_MemWe ? O_MemWData : ld_val;
          if (!O_MemWe) cc_d = cc_from(ld_val[REG_WIDTH-1], ld_val == '0);
          if (!I_MemAck) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
